// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS ID stage: opcodes, PC-select encodings and the control bundle.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] PCSRC_SEQ    = 2'd0;
    localparam logic [1:0] PCSRC_BRANCH = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] ALUOP_MEM    = 2'd0;
    localparam logic [1:0] ALUOP_BRANCH = 2'd1;
    localparam logic [1:0] ALUOP_RTYPE  = 2'd2;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = ctrl_t'(8'h00);

endpackage

// File: rtl/decode_stage_reg_file.sv
// 32x32 register file: two async read ports, one sync write port, sync clear on rst.
// REGFILE_BYPASS_EN: a same-cycle WB write is forwarded to the read ports.
module reg_file #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      i_ra1,
    input  logic [4:0]      i_ra2,
    output logic [XLEN-1:0] o_rd1,
    output logic [XLEN-1:0] o_rd2,
    input  logic            i_we,
    input  logic [4:0]      i_wa,
    input  logic [XLEN-1:0] i_wd
);

    logic [XLEN-1:0] r_regs [NREG];

    // Storage update: clear on reset, $0 is never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_wa != 5'd0)) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    // Read ports, with $0 hard-wired to zero.
    always_comb begin
        o_rd1 = r_regs[i_ra1];
        o_rd2 = r_regs[i_ra2];
`ifdef REGFILE_BYPASS_EN
        if (i_we && (i_wa == i_ra1)) begin
            o_rd1 = i_wd;
        end else begin
            o_rd1 = r_regs[i_ra1];
        end
        if (i_we && (i_wa == i_ra2)) begin
            o_rd2 = i_wd;
        end else begin
            o_rd2 = r_regs[i_ra2];
        end
`endif
        if (i_ra1 == 5'd0) begin
            o_rd1 = '0;
        end else begin
            o_rd1 = o_rd1;
        end
        if (i_ra2 == 5'd0) begin
            o_rd2 = '0;
        end else begin
            o_rd2 = o_rd2;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// MIPS ID stage: decode, register read, branch/jump resolution, hazard detection and ID/EX register.
// REGFILE_BYPASS_EN: register-file write-before-read; WB producers then never stall a branch.
module decode_stage
    import mips_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] idPCin,
    input  logic [31:0]     idInstructionIn,
    input  logic            memRegWrite,
    input  logic [4:0]      memRd,
    input  logic            wbRegWrite,
    input  logic [4:0]      wbRd,
    input  logic [XLEN-1:0] wbData,
    output logic [1:0]      pcSrc,
    output logic [XLEN-1:0] branchAdr,
    output logic [XLEN-1:0] jmpAdr,
    output logic            pcWrite,
    output logic            ifidWrite,
    output logic            ifFlush,
    output logic            exRegWrite,
    output logic            exMemRead,
    output logic            exMemWrite,
    output logic            exMemToReg,
    output logic            exAluSrc,
    output logic            exRegDst,
    output logic [1:0]      exAluOp,
    output logic [XLEN-1:0] exPC,
    output logic [XLEN-1:0] exRsData,
    output logic [XLEN-1:0] exRtData,
    output logic [XLEN-1:0] exImm,
    output logic [4:0]      exRs,
    output logic [4:0]      exRt,
    output logic [4:0]      exRd
);

    logic [5:0]      w_opcode;
    logic [4:0]      w_rs, w_rt, w_rd;
    logic [XLEN-1:0] w_imm, w_rs_data, w_rt_data;
    ctrl_t           w_ctrl;
    logic            w_uses_rs, w_uses_rt, w_is_beq, w_is_bne, w_is_j;
    logic [4:0]      w_ex_rd_eff;
    logic            w_load_use, w_rs_busy, w_rt_busy, w_branch_stall, w_stall, w_taken;

    ctrl_t           r_ctrl;
    logic [XLEN-1:0] r_pc, r_rs_data, r_rt_data, r_imm;
    logic [4:0]      r_rs, r_rt, r_rd;

    assign w_opcode = idInstructionIn[31:26];
    assign w_rs     = idInstructionIn[25:21];
    assign w_rt     = idInstructionIn[20:16];
    assign w_rd     = idInstructionIn[15:11];
    assign w_imm    = {{(XLEN-16){idInstructionIn[15]}}, idInstructionIn[15:0]};

    assign branchAdr = idPCin + (w_imm << 2);
    assign jmpAdr    = {idPCin[XLEN-1:XLEN-4], idInstructionIn[25:0], 2'b00};

    reg_file #(.XLEN(XLEN), .NREG(NREG)) u_reg_file (
        .clk   (clk),
        .rst   (rst),
        .i_ra1 (w_rs),
        .i_ra2 (w_rt),
        .o_rd1 (w_rs_data),
        .o_rd2 (w_rt_data),
        .i_we  (wbRegWrite),
        .i_wa  (wbRd),
        .i_wd  (wbData)
    );

    // Opcode decode into control bundle and source-register usage.
    always_comb begin
        w_ctrl    = CTRL_NOP;
        w_uses_rs = 1'b0;
        w_uses_rt = 1'b0;
        w_is_beq  = 1'b0;
        w_is_bne  = 1'b0;
        w_is_j    = 1'b0;
        case (w_opcode)
            OP_RTYPE: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.reg_dst   = 1'b1;
                w_ctrl.alu_op    = ALUOP_RTYPE;
                w_uses_rs        = 1'b1;
                w_uses_rt        = 1'b1;
            end
            OP_LW: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_read   = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.alu_op     = ALUOP_MEM;
                w_uses_rs         = 1'b1;
            end
            OP_SW: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.alu_op    = ALUOP_MEM;
                w_uses_rs        = 1'b1;
                w_uses_rt        = 1'b1;
            end
            OP_BEQ: begin
                w_ctrl.alu_op = ALUOP_BRANCH;
                w_uses_rs     = 1'b1;
                w_uses_rt     = 1'b1;
                w_is_beq      = 1'b1;
            end
            OP_BNE: begin
                w_ctrl.alu_op = ALUOP_BRANCH;
                w_uses_rs     = 1'b1;
                w_uses_rt     = 1'b1;
                w_is_bne      = 1'b1;
            end
            OP_J: begin
                w_is_j = 1'b1;
            end
            OP_ADDI: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.alu_op    = ALUOP_MEM;
                w_uses_rs        = 1'b1;
            end
            default: begin
                w_ctrl = CTRL_NOP;
            end
        endcase
    end

    // Hazard detection; a branch compares in ID so any in-flight producer of its operands must drain.
    always_comb begin
        w_ex_rd_eff = r_ctrl.reg_dst ? r_rd : r_rt;
        w_load_use  = r_ctrl.mem_read && (r_rt != 5'd0) &&
                      ((w_uses_rs && (r_rt == w_rs)) || (w_uses_rt && (r_rt == w_rt)));
        w_rs_busy   = (w_rs != 5'd0) &&
                      ((r_ctrl.reg_write && (w_ex_rd_eff == w_rs)) || (memRegWrite && (memRd == w_rs))
`ifndef REGFILE_BYPASS_EN
                       || (wbRegWrite && (wbRd == w_rs))
`endif
                      );
        w_rt_busy   = (w_rt != 5'd0) &&
                      ((r_ctrl.reg_write && (w_ex_rd_eff == w_rt)) || (memRegWrite && (memRd == w_rt))
`ifndef REGFILE_BYPASS_EN
                       || (wbRegWrite && (wbRd == w_rt))
`endif
                      );
        w_branch_stall = (w_is_beq || w_is_bne) && (w_rs_busy || w_rt_busy);
        w_stall        = w_load_use || w_branch_stall;
        w_taken        = (w_is_beq && (w_rs_data == w_rt_data)) ||
                         (w_is_bne && (w_rs_data != w_rt_data));
    end

    // Fetch control: a stall freezes fetch and suppresses any redirect.
    always_comb begin
        pcSrc     = PCSRC_SEQ;
        ifFlush   = 1'b0;
        pcWrite   = 1'b1;
        ifidWrite = 1'b1;
        if (w_stall) begin
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
        end else if (w_taken) begin
            pcSrc   = PCSRC_BRANCH;
            ifFlush = 1'b1;
        end else if (w_is_j) begin
            pcSrc   = PCSRC_JUMP;
            ifFlush = 1'b1;
        end else begin
            pcSrc   = PCSRC_SEQ;
            ifFlush = 1'b0;
        end
    end

    // ID/EX pipeline register; stalls insert an all-zero bubble.
    always_ff @(posedge clk) begin
        if (rst || w_stall) begin
            r_ctrl    <= CTRL_NOP;
            r_pc      <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_rs      <= 5'd0;
            r_rt      <= 5'd0;
            r_rd      <= 5'd0;
        end else begin
            r_ctrl    <= (w_is_beq || w_is_bne || w_is_j) ? CTRL_NOP : w_ctrl;
            r_pc      <= idPCin;
            r_rs_data <= w_rs_data;
            r_rt_data <= w_rt_data;
            r_imm     <= w_imm;
            r_rs      <= w_rs;
            r_rt      <= w_rt;
            r_rd      <= w_rd;
        end
    end

    assign exRegWrite = r_ctrl.reg_write;
    assign exMemRead  = r_ctrl.mem_read;
    assign exMemWrite = r_ctrl.mem_write;
    assign exMemToReg = r_ctrl.mem_to_reg;
    assign exAluSrc   = r_ctrl.alu_src;
    assign exRegDst   = r_ctrl.reg_dst;
    assign exAluOp    = r_ctrl.alu_op;
    assign exPC       = r_pc;
    assign exRsData   = r_rs_data;
    assign exRtData   = r_rt_data;
    assign exImm      = r_imm;
    assign exRs       = r_rs;
    assign exRt       = r_rt;
    assign exRd       = r_rd;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected ID/EX entries queued per ID cycle, checked after the edge.
module tb_decode_stage;

    typedef struct packed {
        logic [7:0]  ctrl;
        logic [31:0] pc;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
        logic [14:0] spec;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] idPCin = 32'd0;
    logic [31:0] idInstructionIn = 32'hFC00_0000;
    logic        memRegWrite = 1'b0;
    logic [4:0]  memRd = 5'd0;
    logic        wbRegWrite = 1'b0;
    logic [4:0]  wbRd = 5'd0;
    logic [31:0] wbData = 32'd0;
    logic [1:0]  pcSrc;
    logic [31:0] branchAdr, jmpAdr;
    logic        pcWrite, ifidWrite, ifFlush;
    logic        exRegWrite, exMemRead, exMemWrite, exMemToReg, exAluSrc, exRegDst;
    logic [1:0]  exAluOp;
    logic [31:0] exPC, exRsData, exRtData, exImm;
    logic [4:0]  exRs, exRt, exRd;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    logic [31:0] m_regs [32];

    localparam logic [31:0] NOP = 32'hFC00_0000;

    decode_stage dut (
        .clk(clk), .rst(rst), .idPCin(idPCin), .idInstructionIn(idInstructionIn),
        .memRegWrite(memRegWrite), .memRd(memRd),
        .wbRegWrite(wbRegWrite), .wbRd(wbRd), .wbData(wbData),
        .pcSrc(pcSrc), .branchAdr(branchAdr), .jmpAdr(jmpAdr),
        .pcWrite(pcWrite), .ifidWrite(ifidWrite), .ifFlush(ifFlush),
        .exRegWrite(exRegWrite), .exMemRead(exMemRead), .exMemWrite(exMemWrite),
        .exMemToReg(exMemToReg), .exAluSrc(exAluSrc), .exRegDst(exRegDst), .exAluOp(exAluOp),
        .exPC(exPC), .exRsData(exRsData), .exRtData(exRtData), .exImm(exImm),
        .exRs(exRs), .exRt(exRt), .exRd(exRd)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rd_model(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (wbRegWrite && wbRd == r) return wbData;
`endif
        return m_regs[r];
    endfunction

    // Reference entry; control byte is {regWrite,memRead,memWrite,memToReg,aluSrc,regDst,aluOp}.
    function automatic exp_t model_entry(input logic [31:0] ins, input logic [31:0] pc,
                                         input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        case (ins[31:26])
            6'h00:   e.ctrl = 8'b1000_0110;
            6'h23:   e.ctrl = 8'b1101_1000;
            6'h2B:   e.ctrl = 8'b0010_1000;
            6'h08:   e.ctrl = 8'b1000_1000;
            default: e.ctrl = 8'b0000_0000;
        endcase
        e.pc   = pc;
        e.rsd  = a;
        e.rtd  = b;
        e.imm  = ins[15] ? {16'hFFFF, ins[15:0]} : {16'h0000, ins[15:0]};
        e.spec = ins[25:11];
        return e;
    endfunction

    task automatic check_ex(input exp_t e);
        chk("exCtrl", {24'd0, exRegWrite, exMemRead, exMemWrite, exMemToReg, exAluSrc, exRegDst, exAluOp},
            {24'd0, e.ctrl});
        chk("exPC", exPC, e.pc);
        chk("exRsData", exRsData, e.rsd);
        chk("exRtData", exRtData, e.rtd);
        chk("exImm", exImm, e.imm);
        chk("exSpec", {17'd0, exRs, exRt, exRd}, {17'd0, e.spec});
    endtask

    // One ID cycle: drive, check fetch control and targets, queue the ID/EX entry, check it after the edge.
    task automatic run_cycle(input logic [31:0] ins, input logic [31:0] pc, input logic stall, input logic do_rst);
        logic [31:0] a, b, boff;
        logic        taken;
        logic [1:0]  src;
        exp_t        e;
        @(negedge clk);
        idInstructionIn = ins;
        idPCin = pc;
        rst = do_rst;
        #1;
        a = rd_model(ins[25:21]);
        b = rd_model(ins[20:16]);
        taken = (ins[31:26] == 6'h04 && a == b) || (ins[31:26] == 6'h05 && a != b);
        src = stall ? 2'd0 : taken ? 2'd1 : (ins[31:26] == 6'h02) ? 2'd2 : 2'd0;
        boff = ins[15] ? {14'h3FFF, ins[15:0], 2'b00} : {14'h0000, ins[15:0], 2'b00};
        chk("pcWrite", {31'd0, pcWrite}, {31'd0, ~stall});
        chk("ifidWrite", {31'd0, ifidWrite}, {31'd0, ~stall});
        chk("pcSrc", {30'd0, pcSrc}, {30'd0, src});
        chk("ifFlush", {31'd0, ifFlush}, {31'd0, src != 2'd0});
        chk("branchAdr", branchAdr, pc + boff);
        chk("jmpAdr", jmpAdr, {pc[31:28], ins[25:0], 2'b00});
        if (stall || do_rst) e = '0;
        else e = model_entry(ins, pc, a, b);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (do_rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        end else if (wbRegWrite && wbRd != 5'd0) begin
            m_regs[wbRd] = wbData;
        end
        check_ex(sb.pop_front());
    endtask

    task automatic wb_write(input logic [4:0] r, input logic [31:0] v);
        wbRegWrite = 1'b1;
        wbRd = r;
        wbData = v;
        run_cycle(NOP, 32'h0000_0040, 1'b0, 1'b0);
        wbRegWrite = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        // Reset: two cycles, then all ID/EX fields zero and fetch free-running for a NOP.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_ex('0);
        chk("rst_pcWrite", {31'd0, pcWrite}, 32'd1);
        chk("rst_pcSrc", {30'd0, pcSrc}, 32'd0);
        chk("rst_ifidWrite", {31'd0, ifidWrite}, 32'd1);
        chk("rst_ifFlush", {31'd0, ifFlush}, 32'd0);
        run_cycle(enc_r(5'd5, 5'd0, 5'd7), 32'h0000_0000, 1'b0, 1'b0);
        chk("reg5_zero", exRsData, 32'd0);

        wb_write(5'd1, 32'd7);
        wb_write(5'd2, 32'd7);
        wb_write(5'd4, 32'h11);

        // Load-use: lw $2,0($1); add $3,$2,$4 stalls once.
        run_cycle(enc_i(6'h23, 5'd1, 5'd2, 16'h0000), 32'h0000_0010, 1'b0, 1'b0);
        run_cycle(enc_r(5'd2, 5'd4, 5'd3), 32'h0000_0014, 1'b1, 1'b0);
        memRegWrite = 1'b1;
        memRd = 5'd2;
        run_cycle(enc_r(5'd2, 5'd4, 5'd3), 32'h0000_0014, 1'b0, 1'b0);
        memRegWrite = 1'b0;

        // Taken beq forward, taken bne backward, jump.
        run_cycle(enc_i(6'h04, 5'd1, 5'd2, 16'h0003), 32'h0000_0100, 1'b0, 1'b0);
        chk("beq_target", branchAdr, 32'h0000_010C);
        wb_write(5'd2, 32'd6);
        run_cycle(enc_i(6'h05, 5'd1, 5'd2, 16'hFFFF), 32'h0000_0100, 1'b0, 1'b0);
        run_cycle({6'h02, 26'h000_0040}, 32'h3000_0004, 1'b0, 1'b0);
        chk("j_target", jmpAdr, 32'h3000_0100);

        // Branch after producer: addi $1,$0,5 then beq $1,$0 waits for EX, MEM (and WB without bypass).
        run_cycle(enc_i(6'h08, 5'd0, 5'd1, 16'd5), 32'h0000_0200, 1'b0, 1'b0);
        run_cycle(enc_i(6'h04, 5'd1, 5'd0, 16'h0002), 32'h0000_0204, 1'b1, 1'b0);
        memRegWrite = 1'b1;
        memRd = 5'd1;
        run_cycle(enc_i(6'h04, 5'd1, 5'd0, 16'h0002), 32'h0000_0204, 1'b1, 1'b0);
        memRegWrite = 1'b0;
        wbRegWrite = 1'b1;
        wbRd = 5'd1;
        wbData = 32'd5;
`ifdef REGFILE_BYPASS_EN
        run_cycle(enc_i(6'h04, 5'd1, 5'd0, 16'h0002), 32'h0000_0204, 1'b0, 1'b0);
`else
        run_cycle(enc_i(6'h04, 5'd1, 5'd0, 16'h0002), 32'h0000_0204, 1'b1, 1'b0);
`endif
        wbRegWrite = 1'b0;
        run_cycle(enc_i(6'h04, 5'd1, 5'd0, 16'h0002), 32'h0000_0204, 1'b0, 1'b0);

        // $0 protection: producers of $0 never stall, WB to $0 is dropped.
        run_cycle(enc_i(6'h23, 5'd1, 5'd0, 16'h0000), 32'h0000_0400, 1'b0, 1'b0);
        memRegWrite = 1'b1;
        memRd = 5'd0;
        wbRegWrite = 1'b1;
        wbRd = 5'd0;
        wbData = 32'hDEAD_BEEF;
        run_cycle(enc_i(6'h04, 5'd0, 5'd0, 16'h0001), 32'h0000_0404, 1'b0, 1'b0);
        memRegWrite = 1'b0;
        wbRegWrite = 1'b0;
        run_cycle(enc_r(5'd0, 5'd0, 5'd8), 32'h0000_0408, 1'b0, 1'b0);
        chk("reg0_zero", exRsData, 32'd0);

        // Stall beats a taken beq; reset mid-stall clears state and the stall drops.
        run_cycle(enc_i(6'h23, 5'd0, 5'd3, 16'h0000), 32'h0000_0500, 1'b0, 1'b0);
        run_cycle(enc_i(6'h04, 5'd3, 5'd0, 16'h0004), 32'h0000_0504, 1'b1, 1'b1);
        run_cycle(enc_i(6'h04, 5'd3, 5'd0, 16'h0004), 32'h0000_0504, 1'b0, 1'b0);
        run_cycle(enc_r(5'd1, 5'd4, 5'd9), 32'h0000_0508, 1'b0, 1'b0);
        chk("reg1_cleared", exRsData, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
